mux4_select_sequencer: RTL and testbench
========================================

// Module: mux4_select_sequencer
// PURPOSE
//  Upstream controller for the 4:1 mux (MUX_4x1_Using_2x1).
//  - Drives the mux select S.
//  - Steps through the enabled input channels in a fixed order.
//  - Holds each select for a settle/dwell window, then samples the mux output Y.
//  - Presents the 4 samples as one frame over a valid/ready handshake.
//  - Turns the combinational mux into a time-division channel scanner.
// PARAMETERS
//  DWELL   4  cycles S is held per channel; Y sampled on last cycle (legal 1..255)
//  CNT_W   8  width of dwell counter (must hold DWELL-1)
// PORTS
//  clk          in   1  single clock, rising edge
//  rst_n        in   1  synchronous, active-low reset
//  en           in   1  start/continue scanning
//  ch_mask      in   4  1 = channel included in scan; latched at scan start
//  Y_in         in   1  mux output Y (combinational from S)
//  S            out  2  mux select (registered)
//  frame        out  4  frame[i] = sample of channel i; masked bits = 0
//  frame_valid  out  1  frame holds a complete scan
//  frame_ready  in   1  consumer accepts frame when valid&ready
//  busy         out  1  1 in any state other than IDLE
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE, S=0, frame=0, frame_valid=0, busy=0, counter=0, latched mask=0.
//   - Applies mid-scan or mid-handshake; the partial frame is discarded.
//  States:
//   IDLE
//    - en=1 and ch_mask!=0: latch mask, S<=lowest set channel, cnt<=0, -> SCAN.
//    - ch_mask==0: stay IDLE regardless of en.
//   SCAN
//    - cnt increments each cycle while S stays stable.
//    - cnt==DWELL-1: frame[S] <= Y_in and cnt<=0.
//    - More enabled channels above S: S <= next higher set channel (ascending; no wrap within a scan).
//    - S is highest set channel: -> PRESENT.
//   PRESENT
//    - frame_valid=1; frame and S held stable.
//    - On valid&ready:
//       * frame_valid <= 0.
//       * en=1 and ch_mask!=0: re-latch mask, clear frame, S<=lowest set, -> SCAN.
//       * Otherwise: clear frame, S<=0, -> IDLE.
//  Rules
//   - Masked channels are never selected; their frame bits read 0.
//   - en falling during SCAN does not abort; the scan completes and is presented.
//   - ch_mask changes during SCAN/PRESENT are ignored until the next scan start.
//   - frame_ready while frame_valid=0 is ignored.
//   - frame_valid does not drop without a handshake.
//  Latency
//   - en sampled at edge k: S valid from edge k+1.
//   - frame_valid asserts at edge k+1+N*DWELL, where N = popcount(mask).
//   - Back-to-back scans: the next S is driven the cycle after the handshake.
//  Sampling
//   - Y_in is sampled with S stable for DWELL cycles.
//   - DWELL=1 samples in the same cycle S is first driven; legal because the mux is combinational.
// STRUCTURE
//  - Shared include mux_defs.vh:
//     * state encodings IDLE=2'd0, SCAN=2'd1, PRESENT=2'd2
//     * NUM_CH=4, SEL_W=2
//  - One natural sub-module, mux4_next_channel (combinational):
//     * Inputs: mask and current S.
//     * Outputs: next higher set index and last-flag.
//     * Also used with S=-1 semantics, via a separate first-set output, to find the lowest channel.
//  - The rest is a single FSM plus counter and frame register.
// TESTING
//  1 Full scan: DWELL=4, mask=4'b1111, I=4'b1010 behind a real MUX_4x1_Using_2x1, en at edge 0
//    -> S=0,1,2,3 each held 4 cycles; frame_valid at edge 17; frame=4'b1010.
//  2 Sparse mask: mask=4'b0101, I=4'b1111 -> S visits only 0 then 2; frame=4'b0101; valid at edge 9.
//  3 Backpressure: hold frame_ready=0 for 10 cycles in PRESENT
//    -> frame/S stable, frame_valid stays 1; ready pulse -> valid drops next edge, new scan starts if en=1.
//  4 Zero mask / en low: mask=0, en=1 -> busy=0, S=0 forever.
//    en dropped mid-SCAN -> scan completes, frame presented, then IDLE after handshake.
//  5 Reset mid-operation: rst_n=0 for 1 cycle during SCAN on channel 2
//    -> next edge all outputs at reset values; fresh scan restarts from the lowest channel.
//  6 DWELL=1, mask=4'b1000, Y toggling each cycle
//    -> frame[3] equals Y in the single SCAN cycle; valid at edge 2.

Source files
------------

// File: rtl/mux4_select_sequencer_pkg.sv
// Shared state encodings and channel geometry for the 4:1 mux select sequencer.
package mux4_select_sequencer_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCAN    = 2'd1,
        PRESENT = 2'd2
    } state_t;

endpackage

// File: rtl/mux4_select_sequencer_next_channel.sv
// Channel picker: next enabled channel strictly above sel, plus the lowest enabled channel.
module mux4_next_channel
    import mux4_select_sequencer_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [SEL_W-1:0]  sel,
    output logic [SEL_W-1:0]  next_sel,
    output logic              is_last,
    output logic [SEL_W-1:0]  first_sel
);

    // Both searches walk downward so the lowest qualifying index is the one left standing.
    always_comb begin
        next_sel  = sel;
        is_last   = 1'b1;
        first_sel = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(sel))) begin
                next_sel = SEL_W'(i);
                is_last  = 1'b0;
            end
            if (mask[i]) begin
                first_sel = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/mux4_select_sequencer.sv
// Time-division scanner for a 4:1 mux: steps S over enabled channels, samples Y_in, presents a frame.
// state   | meaning: IDLE = waiting for en with a non-empty mask; SCAN = dwelling on S; PRESENT = frame offered to consumer
module mux4_select_sequencer
    import mux4_select_sequencer_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic              Y_in,
    output logic [SEL_W-1:0]  S,
    output logic [NUM_CH-1:0] frame,
    output logic              frame_valid,
    input  logic              frame_ready,
    output logic              busy
);

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NUM_CH-1:0] frame_q, frame_d;
    logic [NUM_CH-1:0] mask_q, mask_d;

    logic [NUM_CH-1:0] pick_mask;
    logic [SEL_W-1:0]  next_sel;
    logic [SEL_W-1:0]  first_sel;
    logic              is_last;

    // Outside SCAN the picker looks at the live mask so a new scan can start from its lowest channel.
    assign pick_mask = (state_q == SCAN) ? mask_q : ch_mask;

    mux4_next_channel u_next (
        .mask      (pick_mask),
        .sel       (sel_q),
        .next_sel  (next_sel),
        .is_last   (is_last),
        .first_sel (first_sel)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
            frame_q <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
            mask_q  <= mask_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        frame_d = frame_q;
        mask_d  = mask_q;
        case (state_q)
            IDLE: begin
                if (en && (ch_mask != '0)) begin
                    mask_d  = ch_mask;
                    sel_d   = first_sel;
                    cnt_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (cnt_q == DWELL_LAST) begin
                    frame_d[sel_q] = Y_in;
                    cnt_d          = '0;
                    if (is_last) begin
                        state_d = PRESENT;
                    end else begin
                        sel_d = next_sel;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESENT: begin
                if (frame_ready) begin
                    frame_d = '0;
                    cnt_d   = '0;
                    if (en && (ch_mask != '0)) begin
                        mask_d  = ch_mask;
                        sel_d   = first_sel;
                        state_d = SCAN;
                    end else begin
                        sel_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = '0;
                cnt_d   = '0;
                frame_d = '0;
            end
        endcase
    end

    assign S           = sel_q;
    assign frame       = frame_q;
    assign frame_valid = (state_q == PRESENT);
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_mux4_select_sequencer.sv
// Directed bench: DWELL=4 scanner behind a behavioural 4:1 mux, plus a DWELL=1 instance.
module tb_mux4_select_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, ready;
    logic [3:0] mask, in_vec;
    logic       y;
    logic [1:0] s;
    logic [3:0] frame;
    logic       valid, busy;

    logic       en1, ready1, y1;
    logic [3:0] mask1;
    logic [1:0] s1;
    logic [3:0] frame1;
    logic       valid1, busy1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Behavioural stand-in for the combinational 4:1 mux.
    assign y = in_vec[s];

    mux4_select_sequencer #(.DWELL(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .ch_mask(mask), .Y_in(y), .S(s),
        .frame(frame), .frame_valid(valid), .frame_ready(ready), .busy(busy)
    );

    mux4_select_sequencer #(.DWELL(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en1), .ch_mask(mask1), .Y_in(y1), .S(s1),
        .frame(frame1), .frame_valid(valid1), .frame_ready(ready1), .busy(busy1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; mask = 4'hF; in_vec = 4'hF; ready = 1'b0;
        en1 = 1'b1; mask1 = 4'h8; y1 = 1'b1; ready1 = 1'b0;
        tick(); tick();
        n_cmp++; if (s !== 2'd0)     begin n_err++; $display("FAIL reset_S: got %0d want 0", s); end
        n_cmp++; if (frame !== 4'h0) begin n_err++; $display("FAIL reset_frame: got %b want 0000", frame); end
        n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", valid); end
        n_cmp++; if (busy !== 1'b0)  begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (busy1 !== 1'b0 || valid1 !== 1'b0) begin n_err++; $display("FAIL reset_dut1: got busy=%b valid=%b want 0 0", busy1, valid1); end
        en = 1'b0; en1 = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_full_scan();
        mask = 4'b1111; in_vec = 4'b1010; en = 1'b1;
        for (int t = 1; t <= 16; t++) begin
            tick();
            en = 1'b0;
            n_cmp++; if (s !== 2'((t - 1) / 4)) begin n_err++; $display("FAIL full_S t=%0d: got %0d want %0d", t, s, (t - 1) / 4); end
            n_cmp++; if (valid !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL full_flags t=%0d: got valid=%b busy=%b want 0 1", t, valid, busy); end
        end
        tick();
        n_cmp++; if (valid !== 1'b1)    begin n_err++; $display("FAIL full_valid: got %b want 1", valid); end
        n_cmp++; if (frame !== 4'b1010) begin n_err++; $display("FAIL full_frame: got %b want 1010", frame); end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        n_cmp++; if (valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL full_release: got valid=%b busy=%b want 0 0", valid, busy); end
        n_cmp++; if (s !== 2'd0 || frame !== 4'h0) begin n_err++; $display("FAIL full_clear: got S=%0d frame=%b want 0 0000", s, frame); end
    endtask

    task automatic test_sparse_mask();
        logic [1:0] exp_s;
        mask = 4'b0101; in_vec = 4'b1111; en = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            tick();
            en = 1'b0;
            exp_s = (t <= 4) ? 2'd0 : 2'd2;
            n_cmp++; if (s !== exp_s) begin n_err++; $display("FAIL sparse_S t=%0d: got %0d want %0d", t, s, exp_s); end
        end
        tick();
        n_cmp++; if (valid !== 1'b1)    begin n_err++; $display("FAIL sparse_valid: got %b want 1", valid); end
        n_cmp++; if (frame !== 4'b0101) begin n_err++; $display("FAIL sparse_frame: got %b want 0101", frame); end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL sparse_idle: got busy=%b want 0", busy); end
    endtask

    task automatic test_backpressure();
        mask = 4'b0011; in_vec = 4'b1010; en = 1'b1;
        for (int t = 1; t <= 9; t++) tick();
        n_cmp++; if (valid !== 1'b1 || frame !== 4'b0010) begin n_err++; $display("FAIL bp_first: got valid=%b frame=%b want 1 0010", valid, frame); end
        in_vec = 4'b0101; mask = 4'b1000;
        for (int t = 0; t < 10; t++) begin
            tick();
            n_cmp++; if (valid !== 1'b1 || frame !== 4'b0010 || s !== 2'd1) begin
                n_err++; $display("FAIL bp_hold t=%0d: got valid=%b frame=%b S=%0d want 1 0010 1", t, valid, frame, s);
            end
        end
        in_vec = 4'b1010; ready = 1'b1;
        tick();
        ready = 1'b0;
        n_cmp++; if (valid !== 1'b0 || busy !== 1'b1 || s !== 2'd3 || frame !== 4'h0) begin
            n_err++; $display("FAIL bp_restart: got valid=%b busy=%b S=%0d frame=%b want 0 1 3 0000", valid, busy, s, frame);
        end
        en = 1'b0;
        for (int t = 0; t < 4; t++) tick();
        n_cmp++; if (valid !== 1'b1 || frame !== 4'b1000) begin n_err++; $display("FAIL bp_second: got valid=%b frame=%b want 1 1000", valid, frame); end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        n_cmp++; if (busy !== 1'b0 || s !== 2'd0) begin n_err++; $display("FAIL bp_idle: got busy=%b S=%0d want 0 0", busy, s); end
    endtask

    task automatic test_zero_mask_en_drop();
        mask = 4'b0000; en = 1'b1; ready = 1'b1;
        for (int t = 0; t < 5; t++) begin
            tick();
            n_cmp++; if (busy !== 1'b0 || s !== 2'd0 || valid !== 1'b0) begin
                n_err++; $display("FAIL zero_mask t=%0d: got busy=%b S=%0d valid=%b want 0 0 0", t, busy, s, valid);
            end
        end
        ready = 1'b0; mask = 4'b1111; in_vec = 4'b0011;
        tick();
        en = 1'b0;
        for (int t = 2; t <= 16; t++) tick();
        n_cmp++; if (valid !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL endrop_midway: got valid=%b busy=%b want 0 1", valid, busy); end
        tick();
        n_cmp++; if (valid !== 1'b1 || frame !== 4'b0011) begin n_err++; $display("FAIL endrop_frame: got valid=%b frame=%b want 1 0011", valid, frame); end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        n_cmp++; if (busy !== 1'b0 || s !== 2'd0) begin n_err++; $display("FAIL endrop_idle: got busy=%b S=%0d want 0 0", busy, s); end
    endtask

    task automatic test_reset_mid_scan();
        mask = 4'b0111; in_vec = 4'b0111; en = 1'b1;
        for (int t = 1; t <= 9; t++) tick();
        n_cmp++; if (s !== 2'd2) begin n_err++; $display("FAIL rst_pre: got S=%0d want 2", s); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_cmp++; if (s !== 2'd0 || busy !== 1'b0 || valid !== 1'b0 || frame !== 4'h0) begin
            n_err++; $display("FAIL rst_mid: got S=%0d busy=%b valid=%b frame=%b want 0 0 0 0000", s, busy, valid, frame);
        end
        tick();
        en = 1'b0;
        n_cmp++; if (s !== 2'd0 || busy !== 1'b1) begin n_err++; $display("FAIL rst_restart: got S=%0d busy=%b want 0 1", s, busy); end
        for (int t = 0; t < 12; t++) tick();
        n_cmp++; if (valid !== 1'b1 || frame !== 4'b0111) begin n_err++; $display("FAIL rst_frame: got valid=%b frame=%b want 1 0111", valid, frame); end
        ready = 1'b1;
        tick();
        ready = 1'b0;
    endtask

    task automatic test_dwell_one();
        mask1 = 4'b1000; en1 = 1'b1; y1 = 1'b0;
        tick();
        n_cmp++; if (s1 !== 2'd3 || busy1 !== 1'b1 || valid1 !== 1'b0) begin
            n_err++; $display("FAIL d1_scan: got S=%0d busy=%b valid=%b want 3 1 0", s1, busy1, valid1);
        end
        y1 = 1'b1;
        tick();
        y1 = 1'b0;
        n_cmp++; if (valid1 !== 1'b1 || frame1 !== 4'b1000) begin n_err++; $display("FAIL d1_first: got valid=%b frame=%b want 1 1000", valid1, frame1); end
        ready1 = 1'b1;
        tick();
        ready1 = 1'b0; en1 = 1'b0;
        n_cmp++; if (valid1 !== 1'b0 || s1 !== 2'd3 || busy1 !== 1'b1) begin
            n_err++; $display("FAIL d1_b2b: got valid=%b S=%0d busy=%b want 0 3 1", valid1, s1, busy1);
        end
        y1 = 1'b0;
        tick();
        y1 = 1'b1;
        n_cmp++; if (valid1 !== 1'b1 || frame1 !== 4'b0000) begin n_err++; $display("FAIL d1_second: got valid=%b frame=%b want 1 0000", valid1, frame1); end
        ready1 = 1'b1;
        tick();
        ready1 = 1'b0;
        n_cmp++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL d1_idle: got busy=%b want 0", busy1); end
    endtask

    initial begin
        test_reset();
        test_full_scan();
        test_sparse_mask();
        test_backpressure();
        test_zero_mask_en_drop();
        test_reset_mid_scan();
        test_dwell_one();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
